// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed/drain controllers:
// drain FSM state encoding and the wavefront fill-count helper.
package systolic_pkg;

    typedef enum logic [1:0] {
        COUNT  = 2'b00,
        SETTLE = 2'b01,
        DRAIN  = 2'b10
    } drain_state_e;

    // Number of load wavefronts after which PE(N-1,M-1) holds its last operands.
    function automatic int fill_count(input int k, input int n, input int m);
        return k + n + m - 2;
    endfunction

    // Bits needed to index v items, never less than one.
    function automatic int idx_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/result_snapshot.sv
// Capture register for all PE accumulators plus the row multiplexer that
// presents one snapshot row at a time. Output is zero when not valid.
module result_snapshot #(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int DW = 16,
    parameter int RW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture,
    input  logic [N*M*DW-1:0]   acc_in,
    input  logic [RW-1:0]       row,
    input  logic                valid,
    output logic [M*DW-1:0]     row_data
);

    logic [N*M*DW-1:0] snap_r;
    logic [M*DW-1:0]   row_data_s;

    // Snapshot register: loads the whole array only on the capture strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_r <= '0;
        end else if (capture) begin
            snap_r <= acc_in;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Row select: pick the addressed row, zero when no row is being presented.
    always_comb begin
        row_data_s = '0;
        for (int i = 0; i < N; i++) begin
            row_data_s = (valid && (row == RW'(i))) ? snap_r[i*M*DW +: M*DW] : row_data_s;
        end
    end

    assign row_data = row_data_s;

endmodule

// File: rtl/systolic_result_drain.sv
// Drain-side controller for an N x M systolic array: counts load wavefronts,
// waits one settle cycle, snapshots all accumulators and streams them out one
// row per valid/ready beat while holding 'finished'.
// Optional feature macro: DRAIN_CLEAR_EN adds the one-cycle acc_clr pulse
// issued in the first drain cycle.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int K  = 2,
    parameter int DW = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [N*M*DW-1:0]               acc_in,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [M*DW-1:0]                 out_data,
    output logic [idx_width(N)-1:0]         out_row,
    output logic                            finished
`ifdef DRAIN_CLEAR_EN
    ,
    output logic                            acc_clr
`endif
);

    localparam int FILL = fill_count(K, N, M);
    localparam int CW   = idx_width(FILL + 1);
    localparam int RW   = idx_width(N);

    localparam logic [CW-1:0] FILL_C    = CW'(FILL);
    localparam logic [CW-1:0] FILL_M1_C = CW'(FILL - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);

    drain_state_e    state_r, state_s;
    logic [CW-1:0]   load_cnt_r, load_cnt_s;
    logic [RW-1:0]   row_r, row_s;
    logic            valid_r, valid_s;
    logic            capture_s;
    logic            clr_s;
`ifdef DRAIN_CLEAR_EN
    logic            acc_clr_r;
`endif

    // State, counters and the registered valid/finished flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= COUNT;
            load_cnt_r <= '0;
            row_r      <= '0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            load_cnt_r <= load_cnt_s;
            row_r      <= row_s;
            valid_r    <= valid_s;
        end
    end

    // Next-state logic; loads outside COUNT are dropped, SETTLE is fixed at one cycle.
    always_comb begin
        state_s    = state_r;
        load_cnt_s = load_cnt_r;
        row_s      = row_r;
        valid_s    = 1'b0;
        capture_s  = 1'b0;
        clr_s      = 1'b0;
        case (state_r)
            COUNT: begin
                if (load) begin
                    if (load_cnt_r == FILL_M1_C) begin
                        load_cnt_s = FILL_C;
                        state_s    = SETTLE;
                    end else begin
                        load_cnt_s = load_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    load_cnt_s = load_cnt_r;
                end
            end
            SETTLE: begin
                capture_s = 1'b1;
                row_s     = '0;
                state_s   = DRAIN;
                valid_s   = 1'b1;
                clr_s     = 1'b1;
            end
            DRAIN: begin
                if (valid_r && out_ready) begin
                    if (row_r == LAST_ROW) begin
                        state_s    = COUNT;
                        load_cnt_s = '0;
                        row_s      = '0;
                        valid_s    = 1'b0;
                    end else begin
                        row_s   = row_r + {{(RW-1){1'b0}}, 1'b1};
                        valid_s = 1'b1;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s    = COUNT;
                load_cnt_s = '0;
                row_s      = '0;
                valid_s    = 1'b0;
            end
        endcase
    end

`ifdef DRAIN_CLEAR_EN
    // Accumulator clear pulse, high only in the first drain cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_clr_r <= 1'b0;
        end else begin
            acc_clr_r <= clr_s;
        end
    end

    assign acc_clr = acc_clr_r;
`else
    // Without the clear feature the pulse is not used.
    logic unused_clr_s;
    assign unused_clr_s = clr_s;
`endif

    result_snapshot #(
        .N  (N),
        .M  (M),
        .DW (DW),
        .RW (RW)
    ) u_snapshot (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture_s),
        .acc_in   (acc_in),
        .row      (row_r),
        .valid    (valid_r),
        .row_data (out_data)
    );

    assign out_valid = valid_r;
    assign finished  = valid_r;
    assign out_row   = valid_r ? row_r : '0;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed self-checking bench for systolic_result_drain with N=M=K=2, DW=8.
module tb_systolic_result_drain;

    localparam int N  = 2;
    localparam int M  = 2;
    localparam int K  = 2;
    localparam int DW = 8;

    // PE(i,j) = 10*i + j + 1  ->  {0x0C, 0x0B, 0x02, 0x01}
    localparam logic [31:0] ACC_C  = 32'h0C0B_0201;
    localparam logic [31:0] ROW0_C = 32'h0000_0201;
    localparam logic [31:0] ROW1_C = 32'h0000_0C0B;

    logic                clk = 1'b0;
    logic                rst;
    logic                load;
    logic [N*M*DW-1:0]   acc_in;
    logic                out_ready;
    logic                out_valid;
    logic [M*DW-1:0]     out_data;
    logic [0:0]          out_row;
    logic                finished;
`ifdef DRAIN_CLEAR_EN
    logic                acc_clr;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    systolic_result_drain #(
        .N  (N),
        .M  (M),
        .K  (K),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .acc_in    (acc_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .finished  (finished)
`ifdef DRAIN_CLEAR_EN
        ,
        .acc_clr   (acc_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"},    {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_finished"}, {31'd0, finished},  32'd0);
        check_eq({tag, "_row"},      {31'd0, out_row},   32'd0);
        check_eq({tag, "_data"},     {16'd0, out_data},  32'd0);
    endtask

    task automatic check_beat(input string tag, input logic [31:0] row, input logic [31:0] data);
        check_eq({tag, "_valid"},    {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_finished"}, {31'd0, finished},  32'd1);
        check_eq({tag, "_row"},      {31'd0, out_row},   row);
        check_eq({tag, "_data"},     {16'd0, out_data},  data);
    endtask

    // Four loads with out_ready high: SETTLE, row0, row1, back to COUNT.
    task automatic run_basic(input string tag);
        out_ready = 1'b1;
        load      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq({tag, "_fill_valid"}, {31'd0, out_valid}, 32'd0);
        end
        tick();
        load = 1'b0;
        check_idle({tag, "_settle"});
`ifdef DRAIN_CLEAR_EN
        check_eq({tag, "_clr_settle"}, {31'd0, acc_clr}, 32'd0);
`endif
        tick();
        check_beat({tag, "_beat0"}, 32'd0, ROW0_C);
`ifdef DRAIN_CLEAR_EN
        check_eq({tag, "_clr_first"}, {31'd0, acc_clr}, 32'd1);
`endif
        tick();
        check_beat({tag, "_beat1"}, 32'd1, ROW1_C);
`ifdef DRAIN_CLEAR_EN
        check_eq({tag, "_clr_second"}, {31'd0, acc_clr}, 32'd0);
`endif
        tick();
        check_idle({tag, "_done"});
`ifdef DRAIN_CLEAR_EN
        check_eq({tag, "_clr_done"}, {31'd0, acc_clr}, 32'd0);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        out_ready = 1'b0;
        acc_in    = ACC_C;
        #12;
        check_idle("reset");
`ifdef DRAIN_CLEAR_EN
        check_eq("reset_clr", {31'd0, acc_clr}, 32'd0);
`endif
        tick();
        rst = 1'b0;

        // Basic drain
        run_basic("basic");

        // Back-pressure with acc_in changed in the first drain cycle
        out_ready = 1'b0;
        load      = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        load = 1'b0;
        tick();
        check_beat("stall0", 32'd0, ROW0_C);
        acc_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_beat("stall_hold", 32'd0, ROW0_C);
        end
        out_ready = 1'b1;
        tick();
        check_beat("stall_row1", 32'd1, ROW1_C);
        tick();
        check_idle("stall_done");
        acc_in = ACC_C;

        // Loads during SETTLE/DRAIN are ignored
        load = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check_beat("extra_row0", 32'd0, ROW0_C);
        tick();
        check_beat("extra_row1", 32'd1, ROW1_C);
        tick();
        load = 1'b0;
        check_idle("extra_done");
        load = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("three_loads_valid", {31'd0, out_valid}, 32'd0);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        check_eq("fourth_load_settle", {31'd0, out_valid}, 32'd0);
        tick();
        check_beat("fourth_row0", 32'd0, ROW0_C);
        tick();
        check_beat("fourth_row1", 32'd1, ROW1_C);
        tick();
        check_idle("fourth_done");

        // Asynchronous reset while row1 is presented
        out_ready = 1'b1;
        load      = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        load = 1'b0;
        tick();
        check_beat("prerst_row0", 32'd0, ROW0_C);
        tick();
        out_ready = 1'b0;
        check_beat("prerst_row1", 32'd1, ROW1_C);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        #2;
        rst = 1'b0;
        run_basic("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
